// File: rtl/alarm_pkg.sv
// Shared state encoding, default delay constants and width helpers for the alarm controller.
// No logic; the constants size the timer, debounce and siren counters.
// Backpressure: not applicable.
package alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_EXIT_CYCLES     = 16;
    localparam int DEF_ENTRY_CYCLES    = 16;
    localparam int DEF_ALARM_CYCLES    = 64;
    localparam int DEF_BEEP_HALF       = 4;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // The single down-counter must hold the largest delay minus one.
    function automatic int timer_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return width_for(m);
    endfunction

    // Debounce counter counts 0..n inclusive, at least 3 bits wide.
    function automatic int cnt_w(input int n);
        return ($clog2(n + 1) < 3) ? 3 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/alarm_debounce.sv
// Two-flop synchroniser plus saturating run-length counter on an asynchronous level.
// Latency: db rises DEBOUNCE_CYCLES cycles after the synced level, i.e. after edge 2+DEBOUNCE_CYCLES.
// Backpressure: none; any low synced cycle restarts the count.
module alarm_debounce
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int              CNT_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            if (!sync_2) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign db = (cnt == CNT_MAX);

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: button sync/edge detect, debounced trigger, exit/entry/alarm FSM and pulsed siren.
// Latency: button press acts at edge 3, trigger at edge 3+DEBOUNCE_CYCLES; outputs registered except armed.
// Backpressure: none; arm is ignored outside DISARMED and disarm overrides every other event.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int EXIT_CYCLES     = DEF_EXIT_CYCLES,
    parameter int ENTRY_CYCLES    = DEF_ENTRY_CYCLES,
    parameter int ALARM_CYCLES    = DEF_ALARM_CYCLES,
    parameter int BEEP_HALF       = DEF_BEEP_HALF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger,
    input  logic       arm_btn,
    input  logic       disarm_btn,
    output logic       siren,
    output logic       armed,
    output logic       alarm_mem,
    output logic [2:0] state
);

    localparam int                 TIMER_W   = timer_w(EXIT_CYCLES, ENTRY_CYCLES, ALARM_CYCLES);
    localparam logic [TIMER_W-1:0] EXIT_LD   = TIMER_W'(EXIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LD  = TIMER_W'(ENTRY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ALARM_LD  = TIMER_W'(ALARM_CYCLES - 1);
    localparam int                 BEEP_W    = width_for(BEEP_HALF);
    localparam logic [BEEP_W-1:0]  BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

    state_t             state_q;
    logic [TIMER_W-1:0] timer;
    logic [BEEP_W-1:0]  beep_cnt;
    logic               trig_db;

    // [0],[1] synchronise; [2] is the previous synced value for edge detection.
    logic [2:0] arm_sh;
    logic [2:0] disarm_sh;
    logic       arm_p;
    logic       disarm_p;

    alarm_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_trig_db (
        .clk (clk),
        .rst (rst),
        .raw (trigger),
        .db  (trig_db)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_sh    <= '0;
            disarm_sh <= '0;
        end else begin
            arm_sh    <= {arm_sh[1:0], arm_btn};
            disarm_sh <= {disarm_sh[1:0], disarm_btn};
        end
    end

    assign arm_p    = arm_sh[1] & ~arm_sh[2];
    assign disarm_p = disarm_sh[1] & ~disarm_sh[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DISARMED;
            timer     <= '0;
            beep_cnt  <= '0;
            siren     <= 1'b0;
            alarm_mem <= 1'b0;
        end else begin
            if (timer != '0) begin
                timer <= timer - TIMER_W'(1);
            end

            if (state_q == ALARM) begin
                if (beep_cnt == BEEP_LAST) begin
                    beep_cnt <= '0;
                    siren    <= ~siren;
                end else begin
                    beep_cnt <= beep_cnt + BEEP_W'(1);
                end
            end

            if (disarm_p) begin
                state_q <= DISARMED;
                siren   <= 1'b0;
            end else begin
                case (state_q)
                    DISARMED: begin
                        if (arm_p) begin
                            state_q   <= EXIT;
                            timer     <= EXIT_LD;
                            alarm_mem <= 1'b0;
                        end
                    end
                    EXIT: begin
                        if (timer == '0) state_q <= ARMED;
                    end
                    ARMED: begin
                        if (trig_db) begin
                            state_q <= ENTRY;
                            timer   <= ENTRY_LD;
                        end
                    end
                    ENTRY: begin
                        if (timer == '0) begin
                            state_q   <= ALARM;
                            timer     <= ALARM_LD;
                            alarm_mem <= 1'b1;
                            siren     <= 1'b1;
                            beep_cnt  <= '0;
                        end
                    end
                    ALARM: begin
                        if (timer == '0) begin
                            state_q <= ARMED;
                            siren   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= DISARMED;
                        siren   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
    assign armed = (state_q == ARMED) || (state_q == ENTRY) || (state_q == ALARM);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl: timing of arm/exit/entry/alarm, siren pattern, disarm priority, reset.
module tb_alarm_ctrl;

    localparam int S_DISARMED = 0;
    localparam int S_EXIT     = 1;
    localparam int S_ARMED    = 2;
    localparam int S_ENTRY    = 3;
    localparam int S_ALARM    = 4;

    logic       clk;
    logic       rst;
    logic       trigger;
    logic       arm_btn;
    logic       disarm_btn;
    logic       siren;
    logic       armed;
    logic       alarm_mem;
    logic [2:0] state;

    int nvec;
    int nerr;

    alarm_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .arm_btn    (arm_btn),
        .disarm_btn (disarm_btn),
        .siren      (siren),
        .armed      (armed),
        .alarm_mem  (alarm_mem),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        nvec       = 0;
        nerr       = 0;
        rst        = 1'b1;
        trigger    = 1'b0;
        arm_btn    = 1'b0;
        disarm_btn = 1'b0;
        tick();
        tick();
        check("rst_state", int'(state), S_DISARMED);
        check("rst_siren", int'(siren), 0);
        check("rst_armed", int'(armed), 0);
        check("rst_mem", int'(alarm_mem), 0);

        rst = 1'b0;
        repeat (20) tick();
        check("idle_state", int'(state), S_DISARMED);
        check("idle_siren", int'(siren), 0);
        check("idle_armed", int'(armed), 0);
        check("idle_mem", int'(alarm_mem), 0);

        // Arm press: two sync edges, FSM moves on edge 3.
        arm_btn = 1'b1;
        tick();
        tick();
        check("arm_sync_lat", int'(state), S_DISARMED);
        tick();
        check("exit_enter", int'(state), S_EXIT);
        check("exit_armed_out", int'(armed), 0);

        // Trigger held long enough to debounce, but inside EXIT.
        trigger = 1'b1;
        repeat (5) tick();
        arm_btn = 1'b0;
        repeat (4) tick();
        check("exit_trig_ignored", int'(state), S_EXIT);
        trigger = 1'b0;
        repeat (6) tick();
        check("exit_last", int'(state), S_EXIT);
        tick();
        check("armed_state", int'(state), S_ARMED);
        check("armed_out", int'(armed), 1);
        repeat (3) tick();
        check("armed_stays", int'(state), S_ARMED);

        // Three-cycle glitch must not reach ENTRY.
        trigger = 1'b1;
        repeat (3) tick();
        trigger = 1'b0;
        repeat (8) tick();
        check("short_trig", int'(state), S_ARMED);

        // Sustained trigger: ENTRY on edge 7 after assertion.
        trigger = 1'b1;
        repeat (6) tick();
        check("db_edge6", int'(state), S_ARMED);
        tick();
        check("entry_edge7", int'(state), S_ENTRY);
        check("entry_siren", int'(siren), 0);
        repeat (15) tick();
        check("entry_last", int'(state), S_ENTRY);
        check("entry_last_siren", int'(siren), 0);
        tick();
        check("alarm_enter", int'(state), S_ALARM);
        check("alarm_mem_set", int'(alarm_mem), 1);

        for (int k = 0; k < 64; k++) begin
            check("siren_pattern", int'(siren), ((k % 8) < 4) ? 1 : 0);
            if (k == 63) check("alarm_last", int'(state), S_ALARM);
            tick();
        end
        check("rearm_state", int'(state), S_ARMED);
        check("rearm_siren", int'(siren), 0);
        check("rearm_mem", int'(alarm_mem), 1);
        check("rearm_armed", int'(armed), 1);
        tick();
        check("reentry", int'(state), S_ENTRY);

        // Disarm during ENTRY.
        trigger    = 1'b0;
        disarm_btn = 1'b1;
        tick();
        check("dis_entry_siren1", int'(siren), 0);
        tick();
        check("dis_sync_lat", int'(state), S_ENTRY);
        tick();
        check("dis_state", int'(state), S_DISARMED);
        check("dis_siren", int'(siren), 0);
        check("dis_armed", int'(armed), 0);
        check("dis_mem_kept", int'(alarm_mem), 1);
        disarm_btn = 1'b0;
        repeat (4) tick();

        // Re-arming clears the alarm memory.
        arm_btn = 1'b1;
        repeat (3) tick();
        check("rearm2_exit", int'(state), S_EXIT);
        check("rearm2_mem_clr", int'(alarm_mem), 0);
        arm_btn = 1'b0;
        repeat (16) tick();
        check("rearm2_armed", int'(state), S_ARMED);

        // Arm and disarm together: disarm wins; held arm gives no second pulse.
        arm_btn    = 1'b1;
        disarm_btn = 1'b1;
        repeat (2) tick();
        check("both_lat", int'(state), S_ARMED);
        tick();
        check("both_disarm", int'(state), S_DISARMED);
        repeat (4) tick();
        check("held_arm_once", int'(state), S_DISARMED);
        arm_btn    = 1'b0;
        disarm_btn = 1'b0;
        repeat (4) tick();

        // Reach ALARM again, then reset for one cycle.
        arm_btn = 1'b1;
        repeat (3) tick();
        arm_btn = 1'b0;
        repeat (16) tick();
        check("r_armed", int'(state), S_ARMED);
        trigger = 1'b1;
        repeat (7) tick();
        check("r_entry", int'(state), S_ENTRY);
        trigger = 1'b0;
        repeat (16) tick();
        check("r_alarm", int'(state), S_ALARM);
        check("r_alarm_siren", int'(siren), 1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_state", int'(state), S_DISARMED);
        check("mid_rst_siren", int'(siren), 0);
        check("mid_rst_armed", int'(armed), 0);
        check("mid_rst_mem", int'(alarm_mem), 0);
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_state", int'(state), S_DISARMED);
        check("post_rst_siren", int'(siren), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
